// File: rtl/wb_ram_bank_bridge.sv
// Wishbone B4 classic slave in front of an even/odd interleaved 32-bit
// SRAM bank pair. Even words go to the even bank and odd words to the odd bank.
// Writes and misses are acked in cycle 1. Reads are acked in cycle 2 with the
// bank data captured the cycle after the bank read.
//
// Handshake: an access is accepted when cyc & stb are high in IDLE. Exactly one
// single-cycle wbs_ack_o follows, unless cyc drops while a read is waiting.
// The master holds its request until ack. The ACK state is a dead cycle, so the
// next strobe is taken in the cycle after ack.
module wb_ram_bank_bridge #(
    parameter int          COLS      = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    localparam int         AW        = 8 + $clog2(COLS)
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    output logic [AW-1:0] ram_a,
    output logic [31:0]   ram_di,
    output logic          ram_even_en,
    output logic [3:0]    ram_even_we,
    input  logic [31:0]   ram_even_do,
    output logic          ram_odd_en,
    output logic [3:0]    ram_odd_we,
    input  logic [31:0]   ram_odd_do,
    output logic [1:0]    dbg_state
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RDWAIT = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;

    logic [1:0] state;
    logic       bank_sel;
    logic       req;
    logic       hit;
    logic       bank;
    logic [3:0] wr_mask;
    logic       unused_adr;

    // Byte offset within the word has no meaning for a 32-bit bank.
    assign unused_adr = ^wbs_adr_i[1:0];

    assign ram_a     = wbs_adr_i[AW+2:3];
    assign ram_di    = wbs_dat_i;
    assign dbg_state = state;

    // Decode the request and steer the bank strobes, active only in cycle 0.
    always_comb begin
        req         = wbs_cyc_i & wbs_stb_i & (state == ST_IDLE);
        hit         = (wbs_adr_i[31:AW+3] == BASE_ADDR[31:AW+3]);
        bank        = wbs_adr_i[2];
        wr_mask     = wbs_we_i ? wbs_sel_i : 4'b0000;
        ram_even_en = req & hit & ~bank;
        ram_odd_en  = req & hit & bank;
        ram_even_we = ram_even_en ? wr_mask : 4'b0000;
        ram_odd_we  = ram_odd_en  ? wr_mask : 4'b0000;
    end

    // Access FSM: ack generation, read-data capture and bank memory.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= ST_IDLE;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'h0;
            bank_sel  <= 1'b0;
        end else begin
            wbs_ack_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        if (hit && !wbs_we_i) begin
                            state    <= ST_RDWAIT;
                            bank_sel <= bank;
                        end else begin
                            state     <= ST_ACK;
                            wbs_ack_o <= 1'b1;
                            if (!hit) begin
                                wbs_dat_o <= 32'h0;
                            end
                        end
                    end
                end
                ST_RDWAIT: begin
                    if (wbs_cyc_i) begin
                        state     <= ST_ACK;
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= bank_sel ? ram_odd_do : ram_even_do;
                    end else begin
                        // Master abandoned the read: drop it without an ack.
                        state <= ST_IDLE;
                    end
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
